// File: rtl/uart_packet_parser.sv
// -----------------------------------------------------------------------------
// uart_packet_parser
//
// Turns a stream of received UART bytes into packets and 32-bit operand words
// for a downstream ALU.
//
// Packet layout (one byte per rx_valid_i strobe):
//   opcode, reserved, len[7:0], len[15:8], payload...
// The length counts every byte of the packet, header included. Payload bytes
// are packed LSB first into 32-bit words. A short final word has its unused
// upper bytes zero-filled.
//
// Ports
//   clk_i        : system clock, rising edge
//   rst_i        : asynchronous reset, active low
//   rx_data_i    : received byte
//   rx_valid_i   : one-cycle strobe qualifying rx_data_i (no backpressure)
//   opcode_o     : opcode of the current/last packet
//   word_data_o  : assembled operand word
//   word_valid_o : word_data_o/word_last_o hold a word awaiting acceptance
//   word_ready_i : downstream accepts the word
//   word_last_o  : word is the final word of its packet
//   pkt_done_o   : one-cycle pulse when the final packet byte is consumed
//   err_o        : one-cycle error pulse
//   err_code_o   : 01 length, 10 overrun, 11 timeout; held until next error
//
// Build option
//   PKT_PARSER_TIMEOUT_EN : when defined, a packet that sees TIMEOUT_CYCLES
//   idle clocks between bytes is aborted with a timeout error. When undefined
//   the parser waits indefinitely for the next byte.
// -----------------------------------------------------------------------------
module uart_packet_parser #(
   parameter int TIMEOUT_CYCLES = 32768
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_valid_i,
   output logic [7:0]  opcode_o,
   output logic [31:0] word_data_o,
   output logic        word_valid_o,
   input  logic        word_ready_i,
   output logic        word_last_o,
   output logic        pkt_done_o,
   output logic        err_o,
   output logic [1:0]  err_code_o
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [2:0] {
      S_OPCODE  = 3'd0,
      S_RSVD    = 3'd1,
      S_LEN_LO  = 3'd2,
      S_LEN_HI  = 3'd3,
      S_PAYLOAD = 3'd4
   } state_t;

   state_t      state, state_nxt;
   logic [7:0]  len_lo;
   logic [15:0] remaining;   // payload bytes still to come
   logic [1:0]  byte_idx;    // byte lane the next payload byte lands in
   logic [31:0] accum;       // partial word, upper lanes kept zero

   logic [15:0] length_full;
   logic        hdr_short;
   logic        hdr_empty;
   logic        word_done;
   logic        last_byte;
   logic        timeout;
   logic [31:0] word_new;

   assign length_full = {rx_data_i, len_lo};

`ifdef PKT_PARSER_TIMEOUT_EN
   logic [31:0] idle_cnt;

   // Fires on the TIMEOUT_CYCLES-th consecutive idle clock inside a packet.
   assign timeout = (state != S_OPCODE) && !rx_valid_i &&
                    (idle_cnt == 32'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)
         idle_cnt <= '0;
      else if (state == S_OPCODE || rx_valid_i || timeout)
         idle_cnt <= '0;
      else
         idle_cnt <= idle_cnt + 32'd1;
   end
`else
   assign timeout = 1'b0;
`endif

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)
         state <= S_OPCODE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      hdr_short = 1'b0;
      hdr_empty = 1'b0;
      word_done = 1'b0;
      last_byte = 1'b0;
      word_new  = accum;
      word_new[{byte_idx, 3'b000} +: 8] = rx_data_i;

      case (state)
         S_OPCODE: if (rx_valid_i) state_nxt = S_RSVD;
         S_RSVD:   if (rx_valid_i) state_nxt = S_LEN_LO;
         S_LEN_LO: if (rx_valid_i) state_nxt = S_LEN_HI;
         S_LEN_HI: begin
            if (rx_valid_i) begin
               if (length_full < 16'd4) begin
                  hdr_short = 1'b1;
                  state_nxt = S_OPCODE;
               end else if (length_full == 16'd4) begin
                  hdr_empty = 1'b1;
                  state_nxt = S_OPCODE;
               end else begin
                  state_nxt = S_PAYLOAD;
               end
            end
         end
         S_PAYLOAD: begin
            if (rx_valid_i) begin
               last_byte = (remaining == 16'd1);
               word_done = (byte_idx == 2'd3) || last_byte;
               if (last_byte) state_nxt = S_OPCODE;
            end
         end
         default: state_nxt = S_OPCODE;
      endcase

      if (timeout) state_nxt = S_OPCODE;
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         opcode_o     <= '0;
         len_lo       <= '0;
         remaining    <= '0;
         byte_idx     <= '0;
         accum        <= '0;
         word_data_o  <= '0;
         word_valid_o <= 1'b0;
         word_last_o  <= 1'b0;
         pkt_done_o   <= 1'b0;
         err_o        <= 1'b0;
         err_code_o   <= 2'b00;
      end else begin
         pkt_done_o <= 1'b0;
         err_o      <= 1'b0;

         if (rx_valid_i && state == S_OPCODE) opcode_o <= rx_data_i;
         if (rx_valid_i && state == S_LEN_LO) len_lo   <= rx_data_i;

         if (rx_valid_i && state == S_LEN_HI) begin
            remaining <= (length_full > 16'd4) ? length_full - 16'd4 : 16'd0;
            byte_idx  <= '0;
            accum     <= '0;
         end

         if (hdr_short) begin
            err_o      <= 1'b1;
            err_code_o <= 2'b01;
         end
         if (hdr_empty) pkt_done_o <= 1'b1;

         if (rx_valid_i && state == S_PAYLOAD) begin
            remaining <= remaining - 16'd1;
            if (word_done) begin
               accum    <= '0;
               byte_idx <= '0;
            end else begin
               accum    <= word_new;
               byte_idx <= byte_idx + 2'd1;
            end
            if (last_byte) pkt_done_o <= 1'b1;
         end

         // Output slot: a completing word may replace the held one only if
         // the slot is empty or is being handed off this very cycle;
         // otherwise the new word is dropped as an overrun.
         if (word_done) begin
            if (!word_valid_o || word_ready_i) begin
               word_data_o  <= word_new;
               word_last_o  <= last_byte;
               word_valid_o <= 1'b1;
            end else begin
               err_o      <= 1'b1;
               err_code_o <= 2'b10;
            end
         end else if (word_valid_o && word_ready_i) begin
            word_valid_o <= 1'b0;
         end

         // Timeout only happens on an idle clock, so it never collides with
         // the byte-driven updates above; the output slot is left alone.
         if (timeout) begin
            err_o      <= 1'b1;
            err_code_o <= 2'b11;
            accum      <= '0;
            byte_idx   <= '0;
            remaining  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_uart_packet_parser.sv
// -----------------------------------------------------------------------------
// tb_uart_packet_parser
//
// Directed bench for uart_packet_parser. Inputs change 1 ns after the rising
// edge; a negedge monitor records accepted words, pkt_done and err pulses.
// Scenario tasks compare against hand-computed values.
// -----------------------------------------------------------------------------
module tb_uart_packet_parser;

   logic        clk;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  opcode;
   logic [31:0] word_data;
   logic        word_valid;
   logic        word_ready;
   logic        word_last;
   logic        pkt_done;
   logic        err;
   logic [1:0]  err_code;

   int n_checks = 0;
   int n_fail   = 0;

   int          done_cnt = 0;
   int          err_cnt  = 0;
   logic [1:0]  seen_code = 2'b00;
   logic [32:0] wq[$];   // {last, data} of each accepted word

   uart_packet_parser #(.TIMEOUT_CYCLES(100)) dut (
      .clk_i        (clk),
      .rst_i        (rst_n),
      .rx_data_i    (rx_data),
      .rx_valid_i   (rx_valid),
      .opcode_o     (opcode),
      .word_data_o  (word_data),
      .word_valid_o (word_valid),
      .word_ready_i (word_ready),
      .word_last_o  (word_last),
      .pkt_done_o   (pkt_done),
      .err_o        (err),
      .err_code_o   (err_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n) begin
         if (word_valid && word_ready) wq.push_back({word_last, word_data});
         if (pkt_done) done_cnt++;
         if (err) begin
            err_cnt++;
            seen_code = err_code;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drive one byte for one clock; returns 1 ns after the consuming edge.
   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; word_ready = 1'b0;
      idle(3);
      n_checks++; if (opcode !== 8'h00) begin n_fail++; $display("FAIL reset_opcode: got %h want 00", opcode); end
      n_checks++; if (word_data !== 32'h0) begin n_fail++; $display("FAIL reset_word_data: got %h want 0", word_data); end
      n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL reset_word_valid: got %b want 0", word_valid); end
      n_checks++; if (word_last !== 1'b0) begin n_fail++; $display("FAIL reset_word_last: got %b want 0", word_last); end
      n_checks++; if (pkt_done !== 1'b0) begin n_fail++; $display("FAIL reset_pkt_done: got %b want 0", pkt_done); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
      n_checks++; if (err_code !== 2'b00) begin n_fail++; $display("FAIL reset_err_code: got %b want 00", err_code); end
      rst_n = 1'b1;
      idle(2);
   endtask

   task automatic test_two_words;
      logic [7:0] p[12] = '{8'h10, 8'h00, 8'h0C, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                            8'hF0, 8'hDE, 8'hBC, 8'h9A};
      int d0 = done_cnt; int e0 = err_cnt; int q0 = wq.size();
      word_ready = 1'b1;
      foreach (p[i]) send_byte(p[i]);
      n_checks++; if ({pkt_done, word_valid, word_last} !== 3'b111) begin n_fail++; $display("FAIL two_words_final_cycle: done/valid/last got %b want 111", {pkt_done, word_valid, word_last}); end
      idle(3);
      n_checks++; if (opcode !== 8'h10) begin n_fail++; $display("FAIL two_words_opcode: got %h want 10", opcode); end
      n_checks++; if (wq.size() - q0 != 2) begin n_fail++; $display("FAIL two_words_count: got %0d want 2", wq.size() - q0); end
      else begin
         n_checks++; if (wq[q0] !== 33'h0_12345678) begin n_fail++; $display("FAIL two_words_w0: got %h want 012345678", wq[q0]); end
         n_checks++; if (wq[q0+1] !== 33'h1_9ABCDEF0) begin n_fail++; $display("FAIL two_words_w1: got %h want 19abcdef0", wq[q0+1]); end
      end
      n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL two_words_done: got %0d want 1", done_cnt - d0); end
      n_checks++; if (err_cnt - e0 != 0) begin n_fail++; $display("FAIL two_words_err: got %0d want 0", err_cnt - e0); end
   endtask

   task automatic test_len_err;
      logic [7:0] p1[4] = '{8'h11, 8'h00, 8'h03, 8'h00};
      logic [7:0] p2[4] = '{8'h10, 8'h00, 8'h04, 8'h00};
      int d0 = done_cnt; int e0 = err_cnt; int q0 = wq.size();
      word_ready = 1'b1;
      foreach (p1[i]) send_byte(p1[i]);
      n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL len_err_pulse: got %b want 1", err); end
      n_checks++; if (err_code !== 2'b01) begin n_fail++; $display("FAIL len_err_code: got %b want 01", err_code); end
      foreach (p2[i]) send_byte(p2[i]);
      n_checks++; if (pkt_done !== 1'b1) begin n_fail++; $display("FAIL len4_done_pulse: got %b want 1", pkt_done); end
      idle(3);
      n_checks++; if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL len_err_count: got %0d want 1", err_cnt - e0); end
      n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL len4_done_count: got %0d want 1", done_cnt - d0); end
      n_checks++; if (wq.size() - q0 != 0) begin n_fail++; $display("FAIL len4_no_word: got %0d want 0", wq.size() - q0); end
      n_checks++; if (opcode !== 8'h10) begin n_fail++; $display("FAIL len4_opcode: got %h want 10", opcode); end
   endtask

   task automatic test_partial;
      logic [7:0] p[6] = '{8'h12, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB};
      int q0 = wq.size();
      word_ready = 1'b1;
      foreach (p[i]) send_byte(p[i]);
      idle(3);
      n_checks++; if (wq.size() - q0 != 1) begin n_fail++; $display("FAIL partial_count: got %0d want 1", wq.size() - q0); end
      else begin
         n_checks++; if (wq[q0] !== 33'h1_0000BBAA) begin n_fail++; $display("FAIL partial_word: got %h want 10000bbaa", wq[q0]); end
      end
   endtask

   task automatic test_overrun;
      logic [7:0] p[12] = '{8'h10, 8'h00, 8'h0C, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                            8'hF0, 8'hDE, 8'hBC, 8'h9A};
      int d0 = done_cnt; int e0 = err_cnt; int q0 = wq.size();
      word_ready = 1'b0;
      foreach (p[i]) send_byte(p[i]);
      n_checks++; if (err !== 1'b1 || err_code !== 2'b10) begin n_fail++; $display("FAIL overrun_err: got err=%b code=%b want 1/10", err, err_code); end
      idle(2);
      n_checks++; if (word_data !== 32'h12345678 || word_valid !== 1'b1 || word_last !== 1'b0) begin n_fail++; $display("FAIL overrun_hold: got %h v=%b l=%b want 12345678 v=1 l=0", word_data, word_valid, word_last); end
      word_ready = 1'b1;
      idle(4);
      n_checks++; if (wq.size() - q0 != 1) begin n_fail++; $display("FAIL overrun_count: got %0d want 1", wq.size() - q0); end
      else begin
         n_checks++; if (wq[q0] !== 33'h0_12345678) begin n_fail++; $display("FAIL overrun_word: got %h want 012345678", wq[q0]); end
      end
      n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL overrun_drain: got %b want 0", word_valid); end
      n_checks++; if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL overrun_err_count: got %0d want 1", err_cnt - e0); end
      n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL overrun_done: got %0d want 1", done_cnt - d0); end
   endtask

   // Ready rises in exactly the cycle the second word completes.
   task automatic test_back_to_back;
      logic [7:0] p[11] = '{8'h13, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                            8'h05, 8'h06, 8'h07};
      int e0 = err_cnt; int q0 = wq.size();
      word_ready = 1'b0;
      foreach (p[i]) send_byte(p[i]);
      word_ready = 1'b1;
      send_byte(8'h08);
      idle(3);
      n_checks++; if (err_cnt - e0 != 0) begin n_fail++; $display("FAIL b2b_err: got %0d want 0", err_cnt - e0); end
      n_checks++; if (wq.size() - q0 != 2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", wq.size() - q0); end
      else begin
         n_checks++; if (wq[q0] !== 33'h0_04030201) begin n_fail++; $display("FAIL b2b_w0: got %h want 004030201", wq[q0]); end
         n_checks++; if (wq[q0+1] !== 33'h1_08070605) begin n_fail++; $display("FAIL b2b_w1: got %h want 108070605", wq[q0+1]); end
      end
   endtask

   task automatic test_timeout;
      logic [7:0] p[10] = '{8'h0C, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                            8'h55, 8'h66, 8'h77, 8'h88};
      int d0 = done_cnt; int e0 = err_cnt; int q0 = wq.size();
      word_ready = 1'b1;
      send_byte(8'h10);
      send_byte(8'h00);
      idle(100);
`ifdef PKT_PARSER_TIMEOUT_EN
      n_checks++; if (err !== 1'b1 || err_code !== 2'b11) begin n_fail++; $display("FAIL timeout_err: got err=%b code=%b want 1/11", err, err_code); end
      send_byte(8'h20); send_byte(8'h00); send_byte(8'h04); send_byte(8'h00);
      idle(2);
      n_checks++; if (opcode !== 8'h20) begin n_fail++; $display("FAIL timeout_next_opcode: got %h want 20", opcode); end
      n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL timeout_next_done: got %0d want 1", done_cnt - d0); end
      n_checks++; if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL timeout_err_count: got %0d want 1", err_cnt - e0); end
      p[0] = 8'h00;
`else
      n_checks++; if (err_cnt - e0 != 0) begin n_fail++; $display("FAIL no_timeout_err: got %0d want 0", err_cnt - e0); end
      foreach (p[i]) send_byte(p[i]);
      idle(3);
      n_checks++; if (wq.size() - q0 != 2) begin n_fail++; $display("FAIL no_timeout_count: got %0d want 2", wq.size() - q0); end
      else begin
         n_checks++; if (wq[q0] !== 33'h0_44332211) begin n_fail++; $display("FAIL no_timeout_w0: got %h want 044332211", wq[q0]); end
         n_checks++; if (wq[q0+1] !== 33'h1_88776655) begin n_fail++; $display("FAIL no_timeout_w1: got %h want 188776655", wq[q0+1]); end
      end
      n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL no_timeout_done: got %0d want 1", done_cnt - d0); end
      n_checks++; if (opcode !== 8'h10) begin n_fail++; $display("FAIL no_timeout_opcode: got %h want 10", opcode); end
`endif
   endtask

   task automatic test_reset_mid_packet;
      logic [7:0] a[10] = '{8'h14, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                            8'h05, 8'h06};
      logic [7:0] b[12] = '{8'h15, 8'h00, 8'h0C, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                            8'hF0, 8'hDE, 8'hBC, 8'h9A};
      int q0;
      word_ready = 1'b0;
      foreach (a[i]) send_byte(a[i]);
      rst_n = 1'b0;
      #1;
      n_checks++; if ({opcode, word_data, word_valid, word_last, pkt_done, err, err_code} !== 46'h0) begin n_fail++; $display("FAIL midreset_outputs: op=%h d=%h v=%b l=%b done=%b err=%b code=%b want all 0", opcode, word_data, word_valid, word_last, pkt_done, err, err_code); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(1);
      word_ready = 1'b1;
      q0 = wq.size();
      foreach (b[i]) send_byte(b[i]);
      idle(3);
      n_checks++; if (opcode !== 8'h15) begin n_fail++; $display("FAIL midreset_opcode: got %h want 15", opcode); end
      n_checks++; if (wq.size() - q0 != 2) begin n_fail++; $display("FAIL midreset_count: got %0d want 2", wq.size() - q0); end
      else begin
         n_checks++; if (wq[q0] !== 33'h0_12345678) begin n_fail++; $display("FAIL midreset_w0: got %h want 012345678", wq[q0]); end
         n_checks++; if (wq[q0+1] !== 33'h1_9ABCDEF0) begin n_fail++; $display("FAIL midreset_w1: got %h want 19abcdef0", wq[q0+1]); end
      end
   endtask

   initial begin
      test_reset;
      test_two_words;
      test_len_err;
      test_partial;
      test_overrun;
      test_back_to_back;
      test_timeout;
      test_reset_mid_packet;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
